// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Optional leading-zero mask output Blank enabled by defining BIN_BCD_BLANK_EN.
module bin_bcd_seq #(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  St,
    input  logic [BIN_W-1:0]      A,
    output logic [4*DIGITS-1:0]   B,
    output logic                  Busy,
    output logic                  Done
`ifdef BIN_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     Blank
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   shift_q;
    logic [BCD_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_d;

    // Add-3 to every digit >= 5, then shift the next binary bit in; carry out of the top digit is dropped.
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end else begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4];
            end
        end
        acc_d = BCD_W'({acc_adj, shift_q[BIN_W-1]});
    end

`ifdef BIN_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic              higher_zero;

    // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_d     = '0;
        higher_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            higher_zero = higher_zero & (acc_d[4*i +: 4] == 4'd0);
            blank_d[i]  = higher_zero;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            B       <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
`ifdef BIN_BCD_BLANK_EN
            Blank   <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (St) begin
                        shift_q <= A;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(BIN_W);
                        Busy    <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    shift_q <= shift_q << 1;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        B       <= acc_d;
`ifdef BIN_BCD_BLANK_EN
                        Blank   <= blank_d;
`endif
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    Busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
